// File: rtl/port_host_adapter_if.sv
// Host-side handshake bundle for port_host_adapter.
// The host drives tx_data/tx_valid and rx_ready. The adapter drives tx_ready and the rx head/valid.
interface port_host_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] host_tx_data;
    logic                  host_tx_valid;
    logic                  host_tx_ready;
    logic [DATA_WIDTH-1:0] host_rx_data;
    logic                  host_rx_valid;
    logic                  host_rx_ready;

    modport master (
        output host_tx_data,
        output host_tx_valid,
        input  host_tx_ready,
        input  host_rx_data,
        input  host_rx_valid,
        output host_rx_ready
    );

    modport slave (
        input  host_tx_data,
        input  host_tx_valid,
        output host_tx_ready,
        output host_rx_data,
        output host_rx_valid,
        input  host_rx_ready
    );
endinterface

// File: rtl/port_host_adapter.sv
// Host-side adapter for the Mini-SRC CPU I/O ports: queues outport changes for the host,
// holds host-written inport words, and flags when the CPU has halted with all output drained.
module port_host_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_outport_data,
    input  logic                  in_run,
    output logic [DATA_WIDTH-1:0] out_inport_data,
    port_host_adapter_if.slave    host,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_overflow,
    output logic                  out_done
);

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] prev_outport;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  overflow;
    logic                  tx_blocked;

    logic capture;
    logic full;
    logic rx_valid;
    logic pop;
    logic push_ok;
    logic tx_accept;

    assign capture   = (in_outport_data != prev_outport);
    assign full      = (count == FULL_CNT);
    assign rx_valid  = (count != '0);
    assign pop       = rx_valid && host.host_rx_ready;
    // A full FIFO can still take a new value when the head leaves on the same edge.
    assign push_ok   = capture && (!full || pop);
    assign tx_accept = host.host_tx_valid && !tx_blocked;

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Change detector and FIFO control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_outport <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            prev_outport <= in_outport_data;
            count        <= count_nxt;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (capture && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= in_outport_data;
        end
    end

    // Inport holding register; the one-cycle block keeps each word stable for two CPU cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_inport_data <= '0;
            tx_blocked      <= 1'b0;
        end else begin
            tx_blocked <= tx_accept;
            if (tx_accept) begin
                out_inport_data <= host.host_tx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Halt decisions look at post-edge occupancy so same-edge captures and pops both count.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_run) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!in_run) state_nxt = (count_nxt == '0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (in_run)                 state_nxt = S_RUN;
                else if (count_nxt == '0)   state_nxt = S_DONE;
            end
            S_DONE: begin
                if (in_run) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign host.host_tx_ready = !tx_blocked;
    assign host.host_rx_valid = rx_valid;
    assign host.host_rx_data  = fifo_mem[rd_ptr];
    assign out_count          = count;
    assign out_overflow       = overflow;
    assign out_done           = (state == S_DONE);

endmodule

// File: tb/tb_port_host_adapter.sv
// Directed vector bench for port_host_adapter: capture/order, overflow, full push+pop,
// inport handshake pacing, halt/drain FSM and asynchronous reset.
module tb_port_host_adapter;

    logic        clk;
    logic        reset;
    logic [31:0] in_outport_data;
    logic        in_run;
    logic [31:0] out_inport_data;
    logic [2:0]  out_count;
    logic        out_overflow;
    logic        out_done;

    port_host_adapter_if #(.DATA_WIDTH(32)) hif ();

    port_host_adapter #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .CNT_W     (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_outport_data (in_outport_data),
        .in_run          (in_run),
        .out_inport_data (out_inport_data),
        .host            (hif.slave),
        .out_count       (out_count),
        .out_overflow    (out_overflow),
        .out_done        (out_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] outp;
        logic        run;
        logic [31:0] txd;
        logic        txv;
        logic        rxr;
        logic        e_rxv;
        logic [31:0] e_rxd;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic        e_done;
        logic        e_txr;
        logic [31:0] e_inp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_fail;

    function automatic void add(input logic rst_n, input logic [31:0] outp, input logic run,
                                input logic [31:0] txd, input logic txv, input logic rxr,
                                input logic e_rxv, input logic [31:0] e_rxd, input logic [2:0] e_cnt,
                                input logic e_ovf, input logic e_done, input logic e_txr,
                                input logic [31:0] e_inp);
        vec_t v;
        v.rst_n = rst_n; v.outp = outp; v.run = run; v.txd = txd; v.txv = txv; v.rxr = rxr;
        v.e_rxv = e_rxv; v.e_rxd = e_rxd; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
        v.e_done = e_done; v.e_txr = e_txr; v.e_inp = e_inp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //   rst outp  run txd   txv rxr | rxv rxd   cnt ovf done txr inp
        add(0, 'h00, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 1, 'h00);  // 0 reset
        add(1, 'h00, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 1, 'h00);
        add(1, 'h11, 0, 'h00, 0, 0,   1, 'h11, 1, 0, 0, 1, 'h00);  // 2 capture/order
        add(1, 'h11, 0, 'h00, 0, 0,   1, 'h11, 1, 0, 0, 1, 'h00);
        add(1, 'h22, 0, 'h00, 0, 0,   1, 'h11, 2, 0, 0, 1, 'h00);
        add(1, 'h11, 0, 'h00, 0, 0,   1, 'h11, 3, 0, 0, 1, 'h00);
        add(1, 'h11, 0, 'h00, 0, 1,   1, 'h22, 2, 0, 0, 1, 'h00);
        add(1, 'h11, 0, 'h00, 0, 1,   1, 'h11, 1, 0, 0, 1, 'h00);
        add(1, 'h11, 0, 'h00, 0, 1,   0, 'h00, 0, 0, 0, 1, 'h00);
        add(1, 'h11, 0, 'h00, 0, 1,   0, 'h00, 0, 0, 0, 1, 'h00);
        add(1, 'h33, 0, 'h00, 0, 1,   1, 'h33, 1, 0, 0, 1, 'h00);  // 10 push+pop while empty
        add(1, 'h33, 0, 'h00, 0, 1,   0, 'h00, 0, 0, 0, 1, 'h00);
        add(1, 'h33, 0, 'hA5, 1, 0,   0, 'h00, 0, 0, 0, 0, 'hA5);  // 12 inport
        add(1, 'h33, 0, 'h5A, 1, 0,   0, 'h00, 0, 0, 0, 1, 'hA5);
        add(1, 'h33, 0, 'h5A, 1, 0,   0, 'h00, 0, 0, 0, 0, 'h5A);
        add(1, 'h33, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 1, 'h5A);
        add(1, 'h01, 0, 'h00, 0, 0,   1, 'h01, 1, 0, 0, 1, 'h5A);  // 16 overflow
        add(1, 'h02, 0, 'h00, 0, 0,   1, 'h01, 2, 0, 0, 1, 'h5A);
        add(1, 'h03, 0, 'h00, 0, 0,   1, 'h01, 3, 0, 0, 1, 'h5A);
        add(1, 'h04, 0, 'h00, 0, 0,   1, 'h01, 4, 0, 0, 1, 'h5A);
        add(1, 'h05, 0, 'h00, 0, 0,   1, 'h01, 4, 1, 0, 1, 'h5A);
        add(1, 'h06, 0, 'h00, 0, 0,   1, 'h01, 4, 1, 0, 1, 'h5A);
        add(1, 'h06, 0, 'h00, 0, 1,   1, 'h02, 3, 1, 0, 1, 'h5A);
        add(1, 'h06, 0, 'h00, 0, 1,   1, 'h03, 2, 1, 0, 1, 'h5A);
        add(1, 'h06, 0, 'h00, 0, 1,   1, 'h04, 1, 1, 0, 1, 'h5A);
        add(1, 'h06, 0, 'h00, 0, 1,   0, 'h00, 0, 1, 0, 1, 'h5A);
        add(0, 'h06, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 1, 'h00);  // 26 reset, then first-edge capture
        add(1, 'h06, 0, 'h00, 0, 0,   1, 'h06, 1, 0, 0, 1, 'h00);
        add(1, 'h10, 0, 'h00, 0, 0,   1, 'h06, 2, 0, 0, 1, 'h00);
        add(1, 'h20, 0, 'h00, 0, 0,   1, 'h06, 3, 0, 0, 1, 'h00);
        add(1, 'h30, 0, 'h00, 0, 0,   1, 'h06, 4, 0, 0, 1, 'h00);
        add(1, 'h40, 0, 'h00, 0, 1,   1, 'h10, 4, 0, 0, 1, 'h00);  // 31 full push+pop
        add(1, 'h40, 0, 'h00, 0, 1,   1, 'h20, 3, 0, 0, 1, 'h00);
        add(1, 'h40, 0, 'h00, 0, 1,   1, 'h30, 2, 0, 0, 1, 'h00);
        add(1, 'h40, 0, 'h00, 0, 1,   1, 'h40, 1, 0, 0, 1, 'h00);
        add(1, 'h40, 0, 'h00, 0, 1,   0, 'h00, 0, 0, 0, 1, 'h00);
        add(1, 'h40, 1, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 1, 'h00);  // 36 halt/drain
        add(1, 'h50, 1, 'h00, 0, 0,   1, 'h50, 1, 0, 0, 1, 'h00);
        add(1, 'h60, 1, 'h00, 0, 0,   1, 'h50, 2, 0, 0, 1, 'h00);
        add(1, 'h60, 0, 'h00, 0, 0,   1, 'h50, 2, 0, 0, 1, 'h00);
        add(1, 'h60, 0, 'h00, 0, 1,   1, 'h60, 1, 0, 0, 1, 'h00);
        add(1, 'h60, 0, 'h00, 0, 1,   0, 'h00, 0, 0, 1, 1, 'h00);
        add(1, 'h60, 0, 'h00, 0, 0,   0, 'h00, 0, 0, 1, 1, 'h00);
        add(1, 'h60, 1, 'h00, 0, 0,   0, 'h00, 0, 0, 0, 1, 'h00);
        add(1, 'h70, 0, 'h00, 0, 0,   1, 'h70, 1, 0, 0, 1, 'h00);  // 44 capture on halt edge
        add(1, 'h70, 0, 'h00, 0, 1,   0, 'h00, 0, 0, 1, 1, 'h00);
        add(1, 'h71, 0, 'h00, 0, 0,   1, 'h71, 1, 0, 1, 1, 'h00);
        add(1, 'h72, 0, 'h00, 0, 0,   1, 'h71, 2, 0, 1, 1, 'h00);
        add(1, 'h73, 0, 'h00, 0, 0,   1, 'h71, 3, 0, 1, 1, 'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            reset             = vecs[i].rst_n;
            in_outport_data   = vecs[i].outp;
            in_run            = vecs[i].run;
            hif.host_tx_data  = vecs[i].txd;
            hif.host_tx_valid = vecs[i].txv;
            hif.host_rx_ready = vecs[i].rxr;
            @(posedge clk);
            #1;
            check("rx_valid", i, 32'(hif.host_rx_valid), 32'(vecs[i].e_rxv));
            if (vecs[i].e_rxv) check("rx_data", i, hif.host_rx_data, vecs[i].e_rxd);
            check("count",    i, 32'(out_count),         32'(vecs[i].e_cnt));
            check("overflow", i, 32'(out_overflow),      32'(vecs[i].e_ovf));
            check("done",     i, 32'(out_done),          32'(vecs[i].e_done));
            check("tx_ready", i, 32'(hif.host_tx_ready), 32'(vecs[i].e_txr));
            check("inport",   i, out_inport_data,        vecs[i].e_inp);
        end

        // Asynchronous reset mid-cycle with three entries queued and done set.
        #3;
        reset = 1'b0;
        #1;
        check("async_count",    100, 32'(out_count),         32'd0);
        check("async_rx_valid", 100, 32'(hif.host_rx_valid), 32'd0);
        check("async_done",     100, 32'(out_done),          32'd0);
        check("async_tx_ready", 100, 32'(hif.host_tx_ready), 32'd1);

        // Release and confirm the held outport value is recaptured once.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("recapture_count", 101, 32'(out_count),    32'd1);
        check("recapture_data",  101, hif.host_rx_data,  32'h73);
        @(posedge clk);
        #1;
        check("hold_count",      102, 32'(out_count),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
